exc_ctrl: RTL and testbench

- Exception/interrupt controller between the MEM stage and cp0_reg.
- Collects per-instruction exception flags plus pending interrupts and picks one event by fixed priority.
- Drives cp0_reg's excepttype/EPC/BadVAddr inputs for exactly one cycle, flushes the pipeline, and redirects fetch to the exception vector or EPC over a valid/ready handshake.

---
 rtl/exc_ctrl_pkg.sv | 33 +++
 rtl/exc_prio_enc.sv | 49 ++++
 rtl/exc_ctrl.sv | 157 +++++++++++++++
 tb/tb_exc_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes, FSM
// encoding, default vector and the interrupt-pending helper.
package exc_ctrl_pkg;

   localparam int unsigned PC_W_DEF = 32;
   localparam int unsigned EXC_W    = 32;
   localparam int unsigned CNT_W    = 16;

   localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;

   localparam logic [EXC_W-1:0] EXC_NONE = 32'h0000_0000;
   localparam logic [EXC_W-1:0] EXC_INT  = 32'h0000_0001;
   localparam logic [EXC_W-1:0] EXC_ADEL = 32'h0000_0004;
   localparam logic [EXC_W-1:0] EXC_ADES = 32'h0000_0005;
   localparam logic [EXC_W-1:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [EXC_W-1:0] EXC_BP   = 32'h0000_0009;
   localparam logic [EXC_W-1:0] EXC_RI   = 32'h0000_000a;
   localparam logic [EXC_W-1:0] EXC_OV   = 32'h0000_000c;
   localparam logic [EXC_W-1:0] EXC_ERET = 32'h0000_000e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   // Interrupts need IE=1, EXL=0 and at least one unmasked pending line.
   function automatic logic int_pending(input logic [31:0] status,
                                        input logic [31:0] cause);
      return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority selection of one exception event and its faulting address.
module exc_prio_enc
   import exc_ctrl_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic              int_pend_i,
   input  logic              adel_if_i,
   input  logic              ri_i,
   input  logic              syscall_i,
   input  logic              break_i,
   input  logic              ov_i,
   input  logic              adel_i,
   input  logic              ades_i,
   input  logic              eret_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [PC_W-1:0]   badaddr_i,
   output logic [EXC_W-1:0]  code_o,
   output logic [PC_W-1:0]   bad_addr_o
);

   always_comb begin
      code_o     = EXC_NONE;
      bad_addr_o = '0;
      if (int_pend_i) begin
         code_o = EXC_INT;
      end else if (adel_if_i) begin
         code_o     = EXC_ADEL;
         bad_addr_o = pc_i;
      end else if (ri_i) begin
         code_o = EXC_RI;
      end else if (syscall_i) begin
         code_o = EXC_SYS;
      end else if (break_i) begin
         code_o = EXC_BP;
      end else if (ov_i) begin
         code_o = EXC_OV;
      end else if (adel_i) begin
         code_o     = EXC_ADEL;
         bad_addr_o = badaddr_i;
      end else if (ades_i) begin
         code_o     = EXC_ADES;
         bad_addr_o = badaddr_i;
      end else if (eret_i) begin
         code_o = EXC_ERET;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: one-cycle cp0 update + flush, then fetch
// redirect handshake. Define EXC_CNT_EN to add the exc_cnt_o event counter.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int unsigned       PC_W    = PC_W_DEF,
   parameter logic [PC_W-1:0]   EXC_VEC = PC_W'(EXC_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid_i,
   input  logic [PC_W-1:0]   mem_pc_i,
   input  logic              mem_in_delayslot_i,
   input  logic [PC_W-1:0]   mem_badaddr_i,
   input  logic              adel_if_i,
   input  logic              ri_i,
   input  logic              syscall_i,
   input  logic              break_i,
   input  logic              ov_i,
   input  logic              adel_i,
   input  logic              ades_i,
   input  logic              eret_i,
   input  logic [31:0]       cp0_status_i,
   input  logic [31:0]       cp0_cause_i,
   input  logic [31:0]       cp0_epc_i,
   input  logic              fetch_ready_i,
   output logic [31:0]       excepttype_o,
   output logic [PC_W-1:0]   current_inst_addr_o,
   output logic              is_in_delayslot_o,
   output logic [PC_W-1:0]   bad_addr_o,
   output logic              flush_o,
   output logic              stall_o,
   output logic [PC_W-1:0]   newpc_o,
   output logic              newpc_valid_o
`ifdef EXC_CNT_EN
   ,
   output logic [CNT_W-1:0]  exc_cnt_o
`endif
);

   state_e             state_q, state_d;
   logic               int_pend_c;
   logic [EXC_W-1:0]   code_c;
   logic [PC_W-1:0]    bad_c;
   logic               take_c;

   logic [31:0]        excepttype_d;
   logic [PC_W-1:0]    inst_addr_d;
   logic               ds_d;
   logic [PC_W-1:0]    bad_d;
   logic               flush_d;
   logic               stall_d;
   logic [PC_W-1:0]    newpc_d;
   logic               newpc_valid_d;

   logic               unused_ok;
   assign unused_ok = &{1'b0, cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

   assign int_pend_c = int_pending(cp0_status_i, cp0_cause_i);

   exc_prio_enc #(.PC_W(PC_W)) u_prio (
      .int_pend_i (int_pend_c),
      .adel_if_i  (adel_if_i),
      .ri_i       (ri_i),
      .syscall_i  (syscall_i),
      .break_i    (break_i),
      .ov_i       (ov_i),
      .adel_i     (adel_i),
      .ades_i     (ades_i),
      .eret_i     (eret_i),
      .pc_i       (mem_pc_i),
      .badaddr_i  (mem_badaddr_i),
      .code_o     (code_c),
      .bad_addr_o (bad_c)
   );

   // Events are only accepted from IDLE with a live MEM instruction.
   assign take_c = (state_q == ST_IDLE) && mem_valid_i && (code_c != EXC_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q             <= ST_IDLE;
         excepttype_o        <= '0;
         current_inst_addr_o <= '0;
         is_in_delayslot_o   <= 1'b0;
         bad_addr_o          <= '0;
         flush_o             <= 1'b0;
         stall_o             <= 1'b0;
         newpc_o             <= '0;
         newpc_valid_o       <= 1'b0;
      end else begin
         state_q             <= state_d;
         excepttype_o        <= excepttype_d;
         current_inst_addr_o <= inst_addr_d;
         is_in_delayslot_o   <= ds_d;
         bad_addr_o          <= bad_d;
         flush_o             <= flush_d;
         stall_o             <= stall_d;
         newpc_o             <= newpc_d;
         newpc_valid_o       <= newpc_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (take_c) state_d = ST_FLUSH;
         ST_FLUSH:    state_d = ST_REDIRECT;
         ST_REDIRECT: if (newpc_valid_o && fetch_ready_i) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; cp0 fields live for FLUSH only.
   always_comb begin
      excepttype_d  = '0;
      inst_addr_d   = '0;
      ds_d          = 1'b0;
      bad_d         = '0;
      flush_d       = 1'b0;
      stall_d       = (state_d != ST_IDLE);
      newpc_valid_d = (state_d == ST_REDIRECT);
      newpc_d       = newpc_o;
      case (state_q)
         ST_IDLE: begin
            newpc_d = '0;
            if (take_c) begin
               excepttype_d = code_c;
               inst_addr_d  = mem_pc_i;
               ds_d         = mem_in_delayslot_i;
               bad_d        = bad_c;
               flush_d      = 1'b1;
            end
         end
         ST_FLUSH: begin
            newpc_d = (excepttype_o == EXC_ERET) ? PC_W'(cp0_epc_i) : EXC_VEC;
         end
         ST_REDIRECT: begin
            if (state_d == ST_IDLE) newpc_d = '0;
         end
         default: newpc_d = '0;
      endcase
   end

`ifdef EXC_CNT_EN
   // Saturating count of accepted non-eret events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exc_cnt_o <= '0;
      end else if (take_c && (code_c != EXC_ERET) && (exc_cnt_o != {CNT_W{1'b1}})) begin
         exc_cnt_o <= exc_cnt_o + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized events
// checked against a priority-table reference model.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, ds, ready;
   logic [31:0] pc, badaddr, status, cause, epc;
   logic [7:0]  fl;
   logic [31:0] excepttype, cia, bad, newpc;
   logic        isds, flush, stall, nv;
`ifdef EXC_CNT_EN
   logic [15:0] cnt;
   int          cnt_model = 0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exc_ctrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .mem_valid_i         (mem_valid),
      .mem_pc_i            (pc),
      .mem_in_delayslot_i  (ds),
      .mem_badaddr_i       (badaddr),
      .adel_if_i           (fl[0]),
      .ri_i                (fl[1]),
      .syscall_i           (fl[2]),
      .break_i             (fl[3]),
      .ov_i                (fl[4]),
      .adel_i              (fl[5]),
      .ades_i              (fl[6]),
      .eret_i              (fl[7]),
      .cp0_status_i        (status),
      .cp0_cause_i         (cause),
      .cp0_epc_i           (epc),
      .fetch_ready_i       (ready),
      .excepttype_o        (excepttype),
      .current_inst_addr_o (cia),
      .is_in_delayslot_o   (isds),
      .bad_addr_o          (bad),
      .flush_o             (flush),
      .stall_o             (stall),
      .newpc_o             (newpc),
      .newpc_valid_o       (nv)
`ifdef EXC_CNT_EN
      ,
      .exc_cnt_o           (cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the request list from lowest to highest priority.
   function automatic void model(output logic [31:0] code, output logic [31:0] baddr);
      int codes[9];
      int bsel[9];
      logic [8:0] req;
      codes = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
      bsel  = '{0, 1, 0, 0, 0, 0, 2, 2, 0};
      req[0]   = status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 8'h00);
      req[8:1] = fl;
      code  = 32'h0;
      baddr = 32'h0;
      for (int i = 8; i >= 0; i--) begin
         if (req[i]) begin
            code  = 32'(codes[i]);
            baddr = (bsel[i] == 1) ? pc : ((bsel[i] == 2) ? badaddr : 32'h0);
         end
      end
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_flush"}, 32'(flush), 32'h0);
      chk({tag, "_stall"}, 32'(stall), 32'h0);
      chk({tag, "_nv"},    32'(nv),    32'h0);
      chk({tag, "_type"},  excepttype, 32'h0);
   endtask

   // Drives one MEM instruction from IDLE and follows it back to IDLE.
   task automatic run_event(input int delay, input logic junk);
      logic [31:0] exp_code, exp_bad, exp_pc, held;
      model(exp_code, exp_bad);
      mem_valid = 1'b1;
      ready     = (delay == 0);
      step();
      if (exp_code == 32'h0) begin
         chk_idle("noevt");
      end else begin
`ifdef EXC_CNT_EN
         if (exp_code != 32'h0e && cnt_model != 16'hFFFF) cnt_model++;
`endif
         chk("fl_type",  excepttype, exp_code);
         chk("fl_pc",    cia, pc);
         chk("fl_ds",    32'(isds), 32'(ds));
         chk("fl_bad",   bad, exp_bad);
         chk("fl_flush", 32'(flush), 32'h1);
         chk("fl_stall", 32'(stall), 32'h1);
         chk("fl_nv",    32'(nv), 32'h0);
         if (junk) fl = 8'($urandom) | 8'h04;
         exp_pc = (exp_code == 32'h0e) ? epc : 32'hBFC0_0380;
         step();
         epc = $urandom;
         chk("rd_newpc", newpc, exp_pc);
         chk("rd_nv",    32'(nv), 32'h1);
         chk("rd_stall", 32'(stall), 32'h1);
         chk("rd_flush", 32'(flush), 32'h0);
         chk("rd_type",  excepttype, 32'h0);
         chk("rd_bad",   bad, 32'h0);
         held = newpc;
         for (int k = 0; k < delay; k++) begin
            step();
            chk("wait_newpc", newpc, exp_pc);
            chk("wait_nv",    32'(nv), 32'h1);
            chk("wait_stall", 32'(stall), 32'h1);
         end
         ready = 1'b1;
         step();
         chk_idle("ret");
         if (held != exp_pc) chk("held", held, exp_pc);
      end
      mem_valid = 1'b0;
      fl        = 8'h00;
      ready     = 1'b0;
   endtask

   initial begin
      rst = 1'b0; mem_valid = 1'b0; ds = 1'b0; ready = 1'b0;
      pc = '0; badaddr = '0; status = '0; cause = '0; epc = '0; fl = '0;
      step(); step();
      chk_idle("rst");
      chk("rst_newpc", newpc, 32'h0);
      chk("rst_cia",   cia, 32'h0);
      rst = 1'b1;
      step();

      // Interrupt
      status = 32'h0000_FF01; cause = 32'h0000_0400; pc = 32'hBFC0_0100;
      run_event(0, 1'b0);
      // Priority: ri over ov/ades, then adel_if on top
      status = 32'h0; cause = 32'h0; pc = 32'h8000_0010; badaddr = 32'h1234_5678;
      fl = 8'b0101_0010;
      run_event(1, 1'b0);
      fl = 8'b0101_0011; pc = 32'h8000_0002;
      run_event(0, 1'b0);
      // Data-side address errors carry mem_badaddr_i
      fl = 8'b0010_0000; badaddr = 32'h0000_0F03; ds = 1'b1;
      run_event(0, 1'b0);
      fl = 8'b0100_0000; badaddr = 32'h0000_0F06; ds = 1'b0;
      run_event(0, 1'b0);
      // Eret
      fl = 8'b1000_0000; epc = 32'h8000_1234;
      run_event(0, 1'b0);
      // Handshake held off for 5 cycles, syscall arriving while busy
      fl = 8'b0000_0100; pc = 32'h8000_0040;
      run_event(5, 1'b1);
      // EXL masks the interrupt
      status = 32'h0000_FF03; cause = 32'h0000_0400;
      run_event(0, 1'b0);
      // No live instruction: even a pending interrupt is ignored
      status = 32'h0000_FF01; mem_valid = 1'b0;
      step();
      chk_idle("novalid");

      // Async reset during REDIRECT
      mem_valid = 1'b1; ready = 1'b0;
      step(); mem_valid = 1'b0;
      step();
      chk("prerst_nv", 32'(nv), 32'h1);
      rst = 1'b0;
      #1;
      chk_idle("midrst");
      chk("midrst_newpc", newpc, 32'h0);
      step();
      rst = 1'b1; status = 32'h0; cause = 32'h0;
      step();
      chk_idle("postrst");
`ifdef EXC_CNT_EN
      cnt_model = 0;
      chk("cnt_after_rst", 32'(cnt), 32'h0);
`endif

      // Randomized events
      for (int n = 0; n < 60; n++) begin
         status  = $urandom & 32'h0000_FF03;
         cause   = $urandom & 32'h0000_FF00;
         pc      = $urandom;
         badaddr = $urandom;
         epc     = $urandom;
         ds      = 1'($urandom);
         fl      = 8'($urandom & $urandom & $urandom);
         run_event(int'($urandom_range(0, 3)), 1'($urandom));
      end

`ifdef EXC_CNT_EN
      chk("cnt_final", 32'(cnt), 32'(cnt_model));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
